// File: rtl/el2_trace_capture_pkg.sv
// Shared types for the retirement-trace capture buffer.
//   el2_trace_pkt_t       : one captured retirement record, packed as
//                           {addr, insn, tval, exc, intr, ecause} (103 bits)
//   el2_trace_cap_state_e : capture controller state
package el2_trace_capture_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
    logic [31:0] tval;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
  } el2_trace_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_STOPPED = 2'd2
  } el2_trace_cap_state_e;

  localparam int TRACE_PKT_W = $bits(el2_trace_pkt_t);

endpackage

// File: rtl/el2_trace_capture_fifo.sv
// Generic first-word-fall-through register FIFO.
//   clk, rst_l : clock, asynchronous active-low reset
//   push, din  : write request and data (accepted when not full, or when
//                a pop frees the slot in the same cycle)
//   pop, dout  : read request; dout always shows the head entry
//   flush      : synchronous empty, overrides push and pop
//   empty, full, level : occupancy status, derived from the level counter
module el2_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 103,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the write may proceed.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage is reset too so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/el2_trace_capture.sv
// Retirement-trace capture buffer behind the EL2 core wrapper.
//   trace_rv_i_*  : retired-instruction trace from the wrapper
//   cap_en        : capture enable level; stop_on_trap freezes on first trap
//   clear         : synchronous flush of FIFO, drop counter and overflow
//   out_valid/out_ready/out_pkt : FWFT drain handshake to the consumer
//   level, overflow, drop_cnt, stopped : status
module el2_trace_capture
  import el2_trace_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              trace_rv_i_valid_ip,
  input  logic [31:0]       trace_rv_i_insn_ip,
  input  logic [31:0]       trace_rv_i_address_ip,
  input  logic              trace_rv_i_exception_ip,
  input  logic              trace_rv_i_interrupt_ip,
  input  logic [4:0]        trace_rv_i_ecause_ip,
  input  logic [31:0]       trace_rv_i_tval_ip,
  input  logic              cap_en,
  input  logic              stop_on_trap,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output el2_trace_pkt_t    out_pkt,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              stopped
);

  el2_trace_cap_state_e state_q, state_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                 overflow_q, overflow_d;
  el2_trace_pkt_t       in_pkt;
  logic [TRACE_PKT_W-1:0] fifo_dout;
  logic                 push_req, pop_req, drop;
  logic                 fifo_empty, fifo_full;

  assign in_pkt = '{addr:   trace_rv_i_address_ip,
                    insn:   trace_rv_i_insn_ip,
                    tval:   trace_rv_i_tval_ip,
                    exc:    trace_rv_i_exception_ip,
                    intr:   trace_rv_i_interrupt_ip,
                    ecause: trace_rv_i_ecause_ip};

  assign out_valid = ~fifo_empty;
  assign out_pkt   = el2_trace_pkt_t'(fifo_dout);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign stopped   = (state_q == ST_STOPPED);
  assign pop_req   = out_valid & out_ready & ~clear;
  // A full FIFO without a same-cycle pop loses the packet.
  assign drop      = push_req & fifo_full & ~pop_req;

  // Controller: push decision and next state. A trap packet still moves to
  // STOPPED even if it is dropped for lack of space.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap_en) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!cap_en) begin
          state_d = ST_IDLE;
        end else if (trace_rv_i_valid_ip) begin
          push_req = 1'b1;
          if (stop_on_trap && (in_pkt.exc || in_pkt.intr)) state_d = ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        if (!cap_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d  = ST_IDLE;
      push_req = 1'b0;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  el2_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push_req),
    .pop   (pop_req),
    .flush (clear),
    .din   (in_pkt),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

endmodule

// File: tb/tb_el2_trace_capture.sv
// Self-checking bench for el2_trace_capture. A queue-based reference model
// tracks the buffered packets, drop statistics and capture mode, and every
// cycle the DUT outputs are compared against it just after the clock edge.
module tb_el2_trace_capture;
  import el2_trace_capture_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              trace_rv_i_valid_ip = 1'b0;
  logic [31:0]       trace_rv_i_insn_ip = '0;
  logic [31:0]       trace_rv_i_address_ip = '0;
  logic              trace_rv_i_exception_ip = 1'b0;
  logic              trace_rv_i_interrupt_ip = 1'b0;
  logic [4:0]        trace_rv_i_ecause_ip = '0;
  logic [31:0]       trace_rv_i_tval_ip = '0;
  logic              cap_en = 1'b0;
  logic              stop_on_trap = 1'b0;
  logic              clear = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  el2_trace_pkt_t    out_pkt;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic              stopped;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = not capturing, 1 = capturing, 2 = frozen.
  el2_trace_pkt_t    mdl_q[$];
  int                mdl_mode = 0;
  int                mdl_drops = 0;
  bit                mdl_ovf = 0;

  always #5 clk = ~clk;

  el2_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst_l                   (rst_l),
    .trace_rv_i_valid_ip     (trace_rv_i_valid_ip),
    .trace_rv_i_insn_ip      (trace_rv_i_insn_ip),
    .trace_rv_i_address_ip   (trace_rv_i_address_ip),
    .trace_rv_i_exception_ip (trace_rv_i_exception_ip),
    .trace_rv_i_interrupt_ip (trace_rv_i_interrupt_ip),
    .trace_rv_i_ecause_ip    (trace_rv_i_ecause_ip),
    .trace_rv_i_tval_ip      (trace_rv_i_tval_ip),
    .cap_en                  (cap_en),
    .stop_on_trap            (stop_on_trap),
    .clear                   (clear),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_pkt                 (out_pkt),
    .level                   (level),
    .overflow                (overflow),
    .drop_cnt                (drop_cnt),
    .stopped                 (stopped)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mdl_q.delete();
    mdl_mode  = 0;
    mdl_drops = 0;
    mdl_ovf   = 0;
  endtask

  // Apply the rules for one clock edge using the inputs present at the edge.
  task automatic modelEdge();
    el2_trace_pkt_t p;
    int  sz;
    bit  popping, accept, trap;
    p = '{addr: trace_rv_i_address_ip, insn: trace_rv_i_insn_ip,
          tval: trace_rv_i_tval_ip, exc: trace_rv_i_exception_ip,
          intr: trace_rv_i_interrupt_ip, ecause: trace_rv_i_ecause_ip};
    if (clear) begin
      modelReset();
      return;
    end
    sz      = mdl_q.size();
    popping = (sz > 0) && out_ready;
    accept  = 0;
    trap    = 0;
    if (mdl_mode == 0) begin
      if (cap_en) mdl_mode = 1;
    end else if (mdl_mode == 1) begin
      if (!cap_en) mdl_mode = 0;
      else if (trace_rv_i_valid_ip) begin
        accept = 1;
        trap   = stop_on_trap && (p.exc || p.intr);
      end
    end else begin
      if (!cap_en) mdl_mode = 0;
    end
    if (popping) void'(mdl_q.pop_front());
    if (accept) begin
      if (sz < DEPTH || popping) mdl_q.push_back(p);
      else begin
        mdl_ovf = 1;
        if (mdl_drops < (2**CNT_W - 1)) mdl_drops++;
      end
    end
    if (trap) mdl_mode = 2;
  endtask

  task automatic checkOutput();
    check("out_valid", 128'(out_valid), 128'(mdl_q.size() > 0));
    check("level",     128'(level),     128'(mdl_q.size()));
    check("overflow",  128'(overflow),  128'(mdl_ovf));
    check("drop_cnt",  128'(drop_cnt),  128'(mdl_drops));
    check("stopped",   128'(stopped),   128'(mdl_mode == 2));
    if (mdl_q.size() > 0) check("out_pkt", 128'(out_pkt), 128'(mdl_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] addr, input bit e,
                               input bit i, input logic [4:0] c, input bit rdy);
    trace_rv_i_valid_ip     = v;
    trace_rv_i_address_ip   = addr;
    trace_rv_i_insn_ip      = $urandom;
    trace_rv_i_tval_ip      = $urandom;
    trace_rv_i_exception_ip = e;
    trace_rv_i_interrupt_ip = i;
    trace_rv_i_ecause_ip    = c;
    out_ready               = rdy;
    step();
  endtask

  initial begin
    $display("[TB] start");
    modelReset();
    #12;
    checkOutput();
    check("reset_out_pkt", 128'(out_pkt), 128'(0));
    rst_l = 1'b1;

    // Basic capture and drain.
    cap_en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(1, 32'h104, 0, 0, 0, 0);
    applyStimulus(1, 32'h108, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0);
    check("t1_level3", 128'(level), 128'(3));
    check("t1_head", 128'(out_pkt.addr), 128'(32'h100));
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 1);
    check("t1_drained", 128'(level), 128'(0));

    // Overflow: 20 pushes into 16 entries.
    for (int k = 0; k < 20; k++) applyStimulus(1, 32'h200 + 4 * k, 0, 0, 0, 0);
    check("t2_level", 128'(level), 128'(16));
    check("t2_drops", 128'(drop_cnt), 128'(4));
    check("t2_head", 128'(out_pkt.addr), 128'(32'h200));

    // Full with simultaneous push and pop.
    applyStimulus(1, 32'h300, 0, 0, 0, 1);
    check("t3_level", 128'(level), 128'(16));
    check("t3_drops", 128'(drop_cnt), 128'(4));
    for (int k = 0; k < 16; k++) applyStimulus(0, 0, 0, 0, 0, 1);
    check("t3_empty", 128'(out_valid), 128'(0));

    // Stop on trap.
    clear = 1'b1; applyStimulus(0, 0, 0, 0, 0, 0); clear = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    stop_on_trap = 1'b1;
    applyStimulus(1, 32'h400, 0, 0, 0, 0);
    applyStimulus(1, 32'h404, 0, 0, 0, 0);
    applyStimulus(1, 32'h408, 1, 0, 5'd2, 0);
    check("t4_stopped", 128'(stopped), 128'(1));
    for (int k = 0; k < 3; k++) applyStimulus(1, 32'h40c + 4 * k, 0, 0, 0, 0);
    check("t4_level", 128'(level), 128'(3));
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    check("t4_exc", 128'(out_pkt.exc), 128'(1));
    check("t4_ecause", 128'(out_pkt.ecause), 128'(2));
    applyStimulus(0, 0, 0, 0, 0, 1);
    stop_on_trap = 1'b0;

    // Clear with level 5 and drop count 7.
    cap_en = 1'b0; applyStimulus(0, 0, 0, 0, 0, 0);
    cap_en = 1'b1; applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 23; k++) applyStimulus(1, 32'h500 + 4 * k, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) applyStimulus(0, 0, 0, 0, 0, 1);
    check("t5_pre_level", 128'(level), 128'(5));
    check("t5_pre_drops", 128'(drop_cnt), 128'(7));
    clear = 1'b1; applyStimulus(1, 32'h5ff, 0, 0, 0, 1); clear = 1'b0;
    check("t5_level", 128'(level), 128'(0));
    check("t5_drops", 128'(drop_cnt), 128'(0));
    check("t5_ovf", 128'(overflow), 128'(0));
    applyStimulus(1, 32'h600, 0, 0, 0, 0);
    check("t5_idle_nopush", 128'(level), 128'(0));

    // Asynchronous reset mid-burst.
    for (int k = 0; k < 4; k++) applyStimulus(1, 32'h700 + 4 * k, 0, 1, 5'd3, 0);
    #3 rst_l = 1'b0;
    #1;
    modelReset();
    checkOutput();
    check("rst_out_pkt", 128'(out_pkt), 128'(0));
    #2 rst_l = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h800, 0, 0, 0, 0);
    check("t6_latency", 128'(out_valid), 128'(1));
    check("t6_addr", 128'(out_pkt.addr), 128'(32'h800));

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cap_en       = ($urandom % 16) != 0;
      stop_on_trap = ($urandom % 4) == 0;
      clear        = ($urandom % 40) == 0;
      applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 12) == 0,
                    ($urandom % 20) == 0, 5'($urandom), ($urandom % 3) != 0);
      clear = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
